multiplier_right_shifter: RTL and testbench

- Multiplier-operand register for the sequential multiplier datapath; the right-shifting counterpart of the multiplicand left shifter.
- Loads the multiplier operand and presents its LSB to the controller, one bit per step.
- Shifts right (zero fill) on each accepted step, counts steps, and signals completion.
- Completion occurs after WIDTH bits, or earlier when the remaining operand is zero and early exit is enabled.

---
 rtl/multiplier_right_shifter_if.sv | 19 +
 rtl/multiplier_right_shifter.sv | 59 +++++
 tb/tb_multiplier_right_shifter.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/multiplier_right_shifter_if.sv
// multiplier_right_shifter_if: controller-to-shifter bundle for the multiplier-operand register
// master (controller) drives load/data_in/step/abort; slave (shifter) returns
// bit_valid/lsb/data_out/bit_index/busy/done
interface multiplier_right_shifter_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
);
  logic load, step, abort, bit_valid, lsb, busy, done;
  logic [WIDTH-1:0] data_in, data_out;
  logic [CNT_W-1:0] bit_index;
  modport master (
    output load, data_in, step, abort,
    input  bit_valid, lsb, data_out, bit_index, busy, done
  );
  modport slave (
    input  load, data_in, step, abort,
    output bit_valid, lsb, data_out, bit_index, busy, done
  );
endinterface

// File: rtl/multiplier_right_shifter.sv
// multiplier_right_shifter: right-shifting multiplier-operand register presenting one LSB per accepted step
// clk/reset: rising-edge clock, asynchronous active-high reset
// bus (slave): load/data_in start an operation, step consumes lsb, abort cancels;
//   bit_valid/lsb/bit_index present the current bit, data_out the register, busy/done the status
module multiplier_right_shifter #(
  parameter int WIDTH      = 32,
  parameter int CNT_W      = $clog2(WIDTH + 1),
  parameter int EARLY_EXIT = 1
) (
  input logic clk,
  input logic reset,
  multiplier_right_shifter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] sr, sr_n, shr;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic last;
  assign shr = sr >> 1;
  // the step being accepted now consumes the final bit, or leaves only zeros behind
  assign last = cnt == CNT_W'(WIDTH - 1) || (EARLY_EXIT != 0 && shr == '0);
  always_comb begin
    state_n = state;
    sr_n = sr;
    cnt_n = cnt;
    case (state)
      IDLE: if (bus.load) begin
        sr_n = bus.data_in;
        cnt_n = '0;
        state_n = (EARLY_EXIT != 0 && bus.data_in == '0) ? DONE : SHIFT;
      end
      SHIFT: if (bus.abort) begin
        state_n = IDLE;
        cnt_n = '0;
      end else if (bus.step) begin
        sr_n = shr;
        cnt_n = cnt + 1'b1;
        state_n = last ? DONE : SHIFT;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      sr <= '0;
      cnt <= '0;
    end else begin
      state <= state_n;
      sr <= sr_n;
      cnt <= cnt_n;
    end
  assign bus.bit_valid = state == SHIFT;
  assign bus.lsb = sr[0];
  assign bus.data_out = sr;
  assign bus.bit_index = cnt;
  assign bus.busy = state != IDLE;
  assign bus.done = state == DONE;
endmodule

// File: tb/tb_multiplier_right_shifter.sv
// tb_multiplier_right_shifter: directed bench for both EARLY_EXIT settings against a remaining-operand model
module tb_multiplier_right_shifter;
  logic clk = 0, reset = 0, load = 0, step = 0, abort = 0;
  logic [31:0] data_in = 0;
  int n_tests = 0, n_fail = 0;
  always #5 clk = ~clk;

  multiplier_right_shifter_if #(.WIDTH(32)) if0 ();
  multiplier_right_shifter_if #(.WIDTH(32)) if1 ();
  assign if0.load = load;
  assign if0.data_in = data_in;
  assign if0.step = step;
  assign if0.abort = abort;
  assign if1.load = load;
  assign if1.data_in = data_in;
  assign if1.step = step;
  assign if1.abort = abort;
  multiplier_right_shifter #(.WIDTH(32), .EARLY_EXIT(0)) u0 (.clk(clk), .reset(reset), .bus(if0));
  multiplier_right_shifter #(.WIDTH(32), .EARLY_EXIT(1)) u1 (.clk(clk), .reset(reset), .bus(if1));

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  // model: rem = operand bits not yet consumed, k = bits consumed,
  // act = a bit is on offer, fin = completion pulse this cycle
  logic [31:0] m_rem [2];
  int m_k [2];
  bit m_act [2], m_fin [2];
  always @(posedge clk or posedge reset)
    for (int d = 0; d < 2; d++)
      if (reset) begin
        m_rem[d] <= 0;
        m_k[d] <= 0;
        m_act[d] <= 0;
        m_fin[d] <= 0;
      end else if (m_fin[d]) m_fin[d] <= 0;
      else if (m_act[d]) begin
        if (abort) begin
          m_act[d] <= 0;
          m_k[d] <= 0;
        end else if (step) begin
          m_rem[d] <= m_rem[d] >> 1;
          m_k[d] <= m_k[d] + 1;
          if (m_k[d] + 1 == 32 || (d == 1 && (m_rem[d] >> 1) == 0)) begin
            m_act[d] <= 0;
            m_fin[d] <= 1;
          end
        end
      end else if (load) begin
        m_rem[d] <= data_in;
        m_k[d] <= 0;
        if (d == 1 && data_in == 0) m_fin[d] <= 1;
        else m_act[d] <= 1;
      end

  task automatic cmp(input int d, input logic bv, input logic l, input logic [31:0] dout,
                     input logic [5:0] bi, input logic bsy, input logic dn);
    string s;
    s = $sformatf("u%0d", d);
    chk({s, " bit_valid"}, bv, m_act[d]);
    chk({s, " busy"}, bsy, m_act[d] | m_fin[d]);
    chk({s, " done"}, dn, m_fin[d]);
    chk({s, " data_out"}, dout, m_rem[d]);
    if (m_act[d]) begin
      chk({s, " lsb"}, l, m_rem[d][0]);
      chk({s, " bit_index"}, bi, m_k[d]);
    end
  endtask

  always @(negedge clk) begin
    cmp(0, if0.bit_valid, if0.lsb, if0.data_out, if0.bit_index, if0.busy, if0.done);
    cmp(1, if1.bit_valid, if1.lsb, if1.data_out, if1.bit_index, if1.busy, if1.done);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1;
    tick();
    tick();
    reset = 0;
    tick();
  endtask

  // load d with step held high, recording the bits offered by DUT sel until done
  task automatic run_op(input int sel, input logic [31:0] d, input bit sec,
                        output logic [31:0] bits, output int nb, output int dn_at,
                        output int fv, output int maxidx, output logic [31:0] dout);
    logic bv, l, dn;
    logic [5:0] bi;
    load = 1;
    data_in = d;
    step = 1;
    bits = 0;
    nb = 0;
    dn_at = 0;
    fv = 0;
    maxidx = 0;
    dout = 'x;
    for (int n = 1; n <= 40 && dn_at == 0; n++) begin
      tick();
      load = n == 1 && sec;
      data_in = (n == 1 && sec) ? 32'hAAAA_AAAA : d;
      bv = sel == 1 ? if1.bit_valid : if0.bit_valid;
      l = sel == 1 ? if1.lsb : if0.lsb;
      bi = sel == 1 ? if1.bit_index : if0.bit_index;
      dn = sel == 1 ? if1.done : if0.done;
      if (bv) begin
        if (fv == 0) fv = n;
        if (nb < 32) bits[nb] = l;
        if (int'(bi) > maxidx) maxidx = int'(bi);
        nb++;
      end
      if (dn) begin
        dn_at = n;
        dout = sel == 1 ? if1.data_out : if0.data_out;
      end
    end
    load = 0;
    step = 0;
  endtask

  logic [31:0] bits, dout;
  int nb, dn_at, fv, maxidx;

  initial begin
    #1 reset = 1;
    tick();
    tick();
    reset = 0;
    tick();
    chk("reset busy", if1.busy, 0);
    chk("reset bit_index", if1.bit_index, 0);

    // 1: asynchronous reset in the middle of an operation
    load = 1;
    data_in = 32'h0000_000F;
    step = 1;
    tick();
    load = 0;
    tick();
    tick();
    step = 0;
    #2 reset = 1;
    #1;
    chk("async rst bit_valid", if1.bit_valid, 0);
    chk("async rst lsb", if1.lsb, 0);
    chk("async rst data_out", if1.data_out, 0);
    chk("async rst bit_index", if1.bit_index, 0);
    chk("async rst busy", if1.busy, 0);
    chk("async rst u0 data_out", if0.data_out, 0);
    tick();
    reset = 0;
    tick();
    tick();
    chk("post rst busy", if1.busy, 0);
    chk("post rst done", if1.done, 0);

    // 2: full run without early exit
    run_op(0, 32'h8000_0001, 0, bits, nb, dn_at, fv, maxidx, dout);
    chk("full first valid", fv, 1);
    chk("full lsb seq", bits, 32'h8000_0001);
    chk("full nbits", nb, 32);
    chk("full max index", maxidx, 31);
    chk("full done at", dn_at, 33);
    chk("full data_out", dout, 0);
    tick();
    chk("full done once", if0.done, 0);
    do_reset();

    // 3: early exit, then a zero operand
    run_op(1, 32'h0000_0005, 0, bits, nb, dn_at, fv, maxidx, dout);
    chk("early lsb seq", bits, 32'h5);
    chk("early nbits", nb, 3);
    chk("early max index", maxidx, 2);
    chk("early done at", dn_at, 4);
    tick();
    run_op(1, 32'h0, 0, bits, nb, dn_at, fv, maxidx, dout);
    chk("zero done at", dn_at, 1);
    chk("zero nbits", nb, 0);
    do_reset();

    // 4: stall with step low
    load = 1;
    data_in = 32'h0000_0006;
    tick();
    load = 0;
    for (int i = 0; i < 5; i++) begin
      chk("stall bit_valid", if1.bit_valid, 1);
      chk("stall lsb", if1.lsb, 0);
      chk("stall bit_index", if1.bit_index, 0);
      tick();
    end
    step = 1;
    tick();
    step = 0;
    chk("stall step lsb", if1.lsb, 1);
    chk("stall step bit_index", if1.bit_index, 1);
    do_reset();

    // 5: abort beats a simultaneous step
    load = 1;
    data_in = 32'hFFFF_FFFF;
    step = 1;
    tick();
    load = 0;
    tick();
    tick();
    tick();
    abort = 1;
    tick();
    abort = 0;
    step = 0;
    chk("abort busy", if1.busy, 0);
    chk("abort done", if1.done, 0);
    chk("abort data_out", if1.data_out, 32'h1FFF_FFFF);
    chk("abort u0 data_out", if0.data_out, 32'h1FFF_FFFF);
    tick();
    chk("abort no done", if1.done, 0);
    do_reset();

    // 6: load while busy is ignored; reload right after done
    run_op(1, 32'h0000_0003, 1, bits, nb, dn_at, fv, maxidx, dout);
    chk("busy load lsb seq", bits, 32'h3);
    chk("busy load nbits", nb, 2);
    chk("busy load done at", dn_at, 3);
    tick();
    run_op(1, 32'h0000_0002, 0, bits, nb, dn_at, fv, maxidx, dout);
    chk("reload lsb seq", bits, 32'h2);
    chk("reload nbits", nb, 2);
    chk("reload done at", dn_at, 3);
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
